phys_free_list: RTL

Circular free list of physical register tags feeding the rename map table's write ports. Each cycle it hands out up to ALLOC_PORTS free tags to the renamer, accepts up to FREE_PORTS released tags from retirement, and tracks a committed head so a pipeline flush returns all speculatively allocated tags in one cycle.

---
 rtl/phys_free_list_if.sv | 35 +++
 rtl/phys_free_list.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/phys_free_list_if.sv
// Allocation / release / commit bundle between the renamer, retirement and the
// physical-register free list.
interface phys_free_list_if #(
    parameter int PHYS_ADDR_COUNT = 128,
    parameter int ARCH_COUNT      = 32,
    parameter int ALLOC_PORTS     = 4,
    parameter int FREE_PORTS      = 4
);
    localparam int PHYS_ADDR_WIDTH = $clog2(PHYS_ADDR_COUNT);
    localparam int DEPTH           = PHYS_ADDR_COUNT - ARCH_COUNT;
    localparam int CNT_WIDTH       = $clog2(DEPTH + 1);
    localparam int COMMIT_WIDTH    = $clog2(ALLOC_PORTS + 1);

    logic [ALLOC_PORTS-1:0]                      alloc_req;
    logic                                        alloc_ready;
    logic [ALLOC_PORTS-1:0][PHYS_ADDR_WIDTH-1:0] alloc_phys_addr;
    logic [FREE_PORTS-1:0]                       free_en;
    logic [FREE_PORTS-1:0][PHYS_ADDR_WIDTH-1:0]  free_phys_addr;
    logic [COMMIT_WIDTH-1:0]                     commit_cnt;
    logic                                        flush;
    logic [CNT_WIDTH-1:0]                        free_count;
    logic                                        err_o;

    // Renamer/retirement side.
    modport master (
        output alloc_req, free_en, free_phys_addr, commit_cnt, flush,
        input  alloc_ready, alloc_phys_addr, free_count, err_o
    );

    // Free-list side.
    modport slave (
        input  alloc_req, free_en, free_phys_addr, commit_cnt, flush,
        output alloc_ready, alloc_phys_addr, free_count, err_o
    );
endinterface

// File: rtl/phys_free_list.sv
// Circular free list of physical register tags with speculative and committed heads.
// Optional consistency checker enabled by defining PHYS_FREE_LIST_CHECK_EN.
module phys_free_list #(
    parameter int PHYS_ADDR_COUNT = 128,
    parameter int ARCH_COUNT      = 32,
    parameter int ALLOC_PORTS     = 4,
    parameter int FREE_PORTS      = 4
) (
    input  logic            clk,
    input  logic            sync_rst,
    input  logic            clk_en,
    phys_free_list_if.slave bus
);
    localparam int PHYS_ADDR_WIDTH = $clog2(PHYS_ADDR_COUNT);
    localparam int DEPTH           = PHYS_ADDR_COUNT - ARCH_COUNT;
    localparam int PTR_WIDTH       = $clog2(DEPTH);
    localparam int CNT_WIDTH       = $clog2(DEPTH + 1);
    localparam int COMMIT_WIDTH    = $clog2(ALLOC_PORTS + 1);
    localparam int FREE_CNT_WIDTH  = $clog2(FREE_PORTS + 1);

    typedef logic [PTR_WIDTH-1:0]       ptr_t;
    typedef logic [PHYS_ADDR_WIDTH-1:0] tag_t;
    typedef logic [CNT_WIDTH-1:0]       cnt_t;

    // Increments are at most a port group wide, so one conditional subtract wraps.
    function automatic ptr_t ptr_add(input ptr_t ptr, input int unsigned inc);
        int unsigned sum;
        sum = 32'(ptr) + inc;
        if (sum >= 32'(DEPTH)) sum = sum - 32'(DEPTH);
        return ptr_t'(sum);
    endfunction

    tag_t storage [DEPTH];
    ptr_t head_spec, head_commit, tail;
    cnt_t spec_count, commit_count;

    ptr_t head_spec_nxt, head_commit_nxt, tail_nxt;
    cnt_t spec_count_nxt, commit_count_nxt;

    logic [COMMIT_WIDTH-1:0]   n_alloc;
    logic [FREE_CNT_WIDTH-1:0] n_free;
    logic                      alloc_fire;
    ptr_t                      free_slot [FREE_PORTS];

    // Requesting ports are compacted onto consecutive slots from head_spec.
    // NOTE: every output of an always_comb gets a default before any branch, so no latch is inferred.
    always_comb begin
        int unsigned rank;
        rank = 0;
        for (int i = 0; i < ALLOC_PORTS; i++) begin
            bus.alloc_phys_addr[i] = '0;
            if (bus.alloc_req[i]) begin
                bus.alloc_phys_addr[i] = storage[ptr_add(head_spec, rank)];
                rank++;
            end
        end
        n_alloc = COMMIT_WIDTH'(rank);
    end

    always_comb begin
        int unsigned rank;
        rank = 0;
        for (int i = 0; i < FREE_PORTS; i++) begin
            free_slot[i] = ptr_add(tail, rank);
            if (bus.free_en[i]) rank++;
        end
        n_free = FREE_CNT_WIDTH'(rank);
    end

    assign bus.alloc_ready = (32'(n_alloc) <= 32'(spec_count)) && !bus.flush;
    assign alloc_fire      = bus.alloc_ready && (n_alloc != '0) && clk_en;
    assign bus.free_count  = spec_count;

    always_comb begin
        head_commit_nxt  = ptr_add(head_commit, 32'(bus.commit_cnt));
        tail_nxt         = ptr_add(tail, 32'(n_free));
        commit_count_nxt = cnt_t'(32'(commit_count) - 32'(bus.commit_cnt) + 32'(n_free));
        // A flush rewinds the speculative head onto the freshly committed one.
        if (bus.flush) begin
            head_spec_nxt  = head_commit_nxt;
            spec_count_nxt = commit_count_nxt;
        end else begin
            head_spec_nxt  = ptr_add(head_spec, alloc_fire ? 32'(n_alloc) : 32'd0);
            spec_count_nxt = cnt_t'(32'(spec_count) - (alloc_fire ? 32'(n_alloc) : 32'd0)
                                    + 32'(n_free));
        end
    end

    // NOTE: storage is reset because its reset contents define the initial free set.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            for (int k = 0; k < DEPTH; k++) storage[k] <= tag_t'(ARCH_COUNT + k);
            head_spec    <= '0;
            head_commit  <= '0;
            tail         <= '0;
            spec_count   <= cnt_t'(DEPTH);
            commit_count <= cnt_t'(DEPTH);
        end else if (clk_en) begin
            for (int i = 0; i < FREE_PORTS; i++) begin
                if (bus.free_en[i]) storage[free_slot[i]] <= bus.free_phys_addr[i];
            end
            head_spec    <= head_spec_nxt;
            head_commit  <= head_commit_nxt;
            tail         <= tail_nxt;
            spec_count   <= spec_count_nxt;
            commit_count <= commit_count_nxt;
        end
    end

`ifdef PHYS_FREE_LIST_CHECK_EN
    localparam logic [PHYS_ADDR_COUNT-1:0] IN_LIST_RESET = {{DEPTH{1'b1}}, {ARCH_COUNT{1'b0}}};

    logic [PHYS_ADDR_COUNT-1:0] in_list, in_list_nxt, seen;
    logic                       pristine;
    logic                       err_q, err_hit;
    cnt_t                       uncommitted;

    always_comb begin
        int ret_len;
        int off;
        in_list_nxt = in_list;
        seen        = in_list;
        err_hit     = 1'b0;
        uncommitted = commit_count - spec_count;
        ret_len     = 0;
        off         = 0;
        if (32'(commit_count) + 32'(n_free) > 32'(DEPTH)) err_hit = 1'b1;
        if (32'(bus.commit_cnt) > 32'(uncommitted)) err_hit = 1'b1;
        if (alloc_fire) begin
            for (int i = 0; i < ALLOC_PORTS; i++) begin
                if (bus.alloc_req[i]) in_list_nxt[bus.alloc_phys_addr[i]] = 1'b0;
            end
        end
        // Uncommitted allocations that survive the same-cycle commit return to the list.
        if (bus.flush) begin
            if (32'(uncommitted) > 32'(bus.commit_cnt))
                ret_len = int'(uncommitted) - int'(bus.commit_cnt);
            for (int k = 0; k < DEPTH; k++) begin
                off = (k >= int'(head_commit_nxt)) ? k - int'(head_commit_nxt)
                                                   : k + DEPTH - int'(head_commit_nxt);
                if (off < ret_len) in_list_nxt[storage[k]] = 1'b1;
            end
        end
        for (int i = 0; i < FREE_PORTS; i++) begin
            if (bus.free_en[i]) begin
                if (seen[bus.free_phys_addr[i]]) err_hit = 1'b1;
                if (pristine && (32'(bus.free_phys_addr[i]) < 32'(ARCH_COUNT))) err_hit = 1'b1;
                seen[bus.free_phys_addr[i]]        = 1'b1;
                in_list_nxt[bus.free_phys_addr[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            in_list  <= IN_LIST_RESET;
            pristine <= 1'b1;
            err_q    <= 1'b0;
        end else if (clk_en) begin
            in_list <= in_list_nxt;
            if (alloc_fire) pristine <= 1'b0;
            err_q <= err_q | err_hit;
        end
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif
endmodule
